// File: rtl/fetch_stage_ctrl.sv
// Fetch stage control: owns the PC and IF/ID register, applies hold/flush/redirect and a stall watchdog.
// Optional stall performance counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage_ctrl #(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     INSTR_W   = 32,
  parameter logic [PC_W-1:0] PC_RESET  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned     MAX_STALL = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               enable,
  input  logic               hold_pc,
  input  logic               hold_if_id,
  input  logic               flush,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    imem_addr,
  output logic [PC_W-1:0]    pc_IF_ID,
  output logic [INSTR_W-1:0] instruction_IF_ID,
  output logic               valid_IF_ID,
  output logic               stall_err,
  output logic [31:0]        perf_stall_cnt
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam int unsigned     CNT_W   = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

  logic [1:0]         state_r,      state_next_s;
  logic [PC_W-1:0]    pc_r,         pc_next_s;
  logic [PC_W-1:0]    ifid_pc_r,    ifid_pc_next_s;
  logic [INSTR_W-1:0] ifid_instr_r, ifid_instr_next_s;
  logic               ifid_valid_r, ifid_valid_next_s;
  logic [CNT_W-1:0]   run_cnt_r,    run_cnt_next_s;
  logic               stall_err_r,  stall_err_next_s;

  // Next-state decode: enable gates everything, then flush > holds > normal fetch.
  always_comb begin
    state_next_s      = state_r;
    pc_next_s         = pc_r;
    ifid_pc_next_s    = ifid_pc_r;
    ifid_instr_next_s = ifid_instr_r;
    ifid_valid_next_s = ifid_valid_r;
    run_cnt_next_s    = run_cnt_r;
    stall_err_next_s  = stall_err_r;
    if (enable) begin
      case (state_r)
        ST_BOOT: begin
          ifid_instr_next_s = NOP_INSTR;
          ifid_pc_next_s    = {PC_W{1'b0}};
          ifid_valid_next_s = 1'b0;
          run_cnt_next_s    = {CNT_W{1'b0}};
          state_next_s      = ST_RUN;
        end
        ST_RUN, ST_STALL: begin
          if (flush) begin
            pc_next_s         = redirect_pc;
            ifid_instr_next_s = NOP_INSTR;
            ifid_pc_next_s    = {PC_W{1'b0}};
            ifid_valid_next_s = 1'b0;
            run_cnt_next_s    = {CNT_W{1'b0}};
            state_next_s      = ST_RUN;
          end else if (hold_pc || hold_if_id) begin
            if (hold_pc) begin
              pc_next_s = pc_r;
            end else begin
              pc_next_s = pc_r + PC_W'(4);
            end
            if (hold_if_id) begin
              ifid_instr_next_s = ifid_instr_r;
              ifid_pc_next_s    = ifid_pc_r;
              ifid_valid_next_s = ifid_valid_r;
            end else begin
              ifid_instr_next_s = imem_rdata;
              ifid_pc_next_s    = pc_r;
              ifid_valid_next_s = 1'b1;
            end
            if (run_cnt_r < MAX_CNT) begin
              run_cnt_next_s = run_cnt_r + CNT_W'(1);
            end else begin
              run_cnt_next_s = MAX_CNT;
            end
            // Sticky: the edge that brings the run to its limit raises the flag.
            if (run_cnt_next_s == MAX_CNT) begin
              stall_err_next_s = 1'b1;
            end else begin
              stall_err_next_s = stall_err_r;
            end
            state_next_s = ST_STALL;
          end else begin
            pc_next_s         = pc_r + PC_W'(4);
            ifid_instr_next_s = imem_rdata;
            ifid_pc_next_s    = pc_r;
            ifid_valid_next_s = 1'b1;
            run_cnt_next_s    = {CNT_W{1'b0}};
            state_next_s      = ST_RUN;
          end
        end
        default: begin
          pc_next_s         = PC_RESET;
          ifid_instr_next_s = NOP_INSTR;
          ifid_pc_next_s    = {PC_W{1'b0}};
          ifid_valid_next_s = 1'b0;
          run_cnt_next_s    = {CNT_W{1'b0}};
          state_next_s      = ST_BOOT;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State, PC, IF/ID and watchdog registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r      <= ST_BOOT;
      pc_r         <= PC_RESET;
      ifid_pc_r    <= {PC_W{1'b0}};
      ifid_instr_r <= NOP_INSTR;
      ifid_valid_r <= 1'b0;
      run_cnt_r    <= {CNT_W{1'b0}};
      stall_err_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pc_r         <= pc_next_s;
      ifid_pc_r    <= ifid_pc_next_s;
      ifid_instr_r <= ifid_instr_next_s;
      ifid_valid_r <= ifid_valid_next_s;
      run_cnt_r    <= run_cnt_next_s;
      stall_err_r  <= stall_err_next_s;
    end
  end

  assign imem_addr         = pc_r;
  assign pc_IF_ID          = ifid_pc_r;
  assign instruction_IF_ID = ifid_instr_r;
  assign valid_IF_ID       = ifid_valid_r;
  assign stall_err         = stall_err_r;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_r;

  // Saturating count of enabled PC-hold cycles outside BOOT; flush cycles excluded.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_cnt_r <= 32'd0;
    end else if (enable && (state_r != ST_BOOT) && hold_pc && !flush &&
                 (perf_cnt_r != 32'hFFFF_FFFF)) begin
      perf_cnt_r <= perf_cnt_r + 32'd1;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign perf_stall_cnt = perf_cnt_r;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- Consumer end of the load-use stall signals: owns the PC register and the IF/ID pipeline register, and applies hold, flush and redirect requests coming from the hazard and branch logic.
- Sits between instruction memory (combinational read) and the ID stage of the 5-stage pipeline.
- Inserts NOP bubbles on flush and tracks consecutive stall cycles with a watchdog.

Parameters:
- PC_W, 32, program counter / address width.
- INSTR_W, 32, instruction width.
- PC_RESET, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
- MAX_STALL, 8, consecutive stall cycles before watchdog error.

Ports:
- clk, input, 1, system clock, rising edge.
- arst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, global pipeline enable; 0 freezes all state.
- hold_pc, input, 1, 1 = do not update PC this cycle.
- hold_if_id, input, 1, 1 = IF/ID keeps current contents.
- flush, input, 1, 1 = taken branch/jump; redirect and squash.
- redirect_pc, input, PC_W, target PC, valid when flush=1.
- imem_rdata, input, INSTR_W, instruction at imem_addr (same-cycle).
- imem_addr, output, PC_W, current PC (combinational from PC register).
- pc_IF_ID, output, PC_W, PC of the instruction in IF/ID.
- instruction_IF_ID, output, INSTR_W, instruction in IF/ID.
- valid_IF_ID, output, 1, IF/ID holds a real instruction.
- stall_err, output, 1, sticky watchdog flag.
- perf_stall_cnt, output, 32, stall cycle counter (PERF_CNT_EN only; tie 0 otherwise).

Behaviour:
- Reset (async, arst_n=0):
  - PC=PC_RESET; instruction_IF_ID=NOP_INSTR; pc_IF_ID=0; valid_IF_ID=0.
  - stall_err=0; stall run counter=0; perf_stall_cnt=0; FSM=BOOT.
- FSM states: BOOT, RUN, STALL. All transitions are gated by enable=1; with enable=0 every register holds, including the counters.
- BOOT:
  - Lasts exactly one enabled cycle; PC does not advance; IF/ID loads NOP with valid=0.
  - Next state is RUN. hold and flush inputs are ignored in BOOT.
- RUN and STALL, per enabled cycle, in priority order:
  1. flush=1 (wins over both holds): PC<=redirect_pc; IF/ID<=NOP_INSTR, pc_IF_ID<=0, valid<=0; next state RUN; run counter cleared.
  2. hold_pc=1 or hold_if_id=1:
     - hold_pc=1: PC holds.
     - hold_if_id=1: IF/ID holds.
     - Each hold is applied independently; when only one is set, the other register updates normally.
     - Next state STALL; run counter increments, saturating at MAX_STALL.
  3. Otherwise:
     - PC<=PC+4, modulo 2^PC_W (wraps from all-ones-minus-3 to 0 with no error).
     - IF/ID<={imem_rdata, PC}, valid<=1.
     - Next state RUN; run counter cleared.
- Watchdog: when the run counter reaches MAX_STALL while still in STALL, stall_err is set on that edge. It stays set until reset.
- Latency:
  - Instruction fetched at PC appears in IF/ID one cycle later.
  - Flush takes effect on the next edge: imem_addr = redirect_pc the following cycle.
- Reset asserted mid-stall or mid-flush returns to BOOT immediately, with all values as listed under Reset.
- redirect_pc bits [1:0] pass through unmodified; alignment is the branch unit's responsibility.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: perf_stall_cnt increments by 1 on every enabled cycle where hold_pc=1 and flush=0, outside BOOT. It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Undefined: no counter register exists; perf_stall_cnt is driven constant 0.

Test Plan:
- Reset release with PC_RESET=0, enable=1, imem_rdata=32'hA: BOOT cycle → valid_IF_ID=0, imem_addr=0. Next edge → IF/ID={32'hA, pc 0}, valid=1, imem_addr=4.
- Single-cycle load-use stall (hold_pc=hold_if_id=1 for 1 cycle at PC=8): PC stays 8 and IF/ID unchanged for one cycle, then resumes with PC=12.
- Flush and hold together (flush=1, redirect_pc=0x100, hold_pc=1): imem_addr=0x100 next cycle; IF/ID=NOP_INSTR, valid=0; stall_err stays 0.
- Stall held for 8 consecutive cycles with MAX_STALL=8: stall_err=1 after the 8th edge. It stays 1 after the holds are released, until arst_n is asserted.
- PC wrap (PC_W=32, PC=32'hFFFF_FFFC, no hold) → next PC=0, valid IF/ID captures pc 32'hFFFF_FFFC.
- With FETCH_PERF_CNT_EN defined, 3 hold_pc cycles plus 1 flush+hold cycle → perf_stall_cnt=3. With enable=0 during a hold, the count does not change.
